// File: rtl/uniboard_bus_master.sv
// Initiator for the Uniboard peripheral register bus: one command in, one strobed
// bus transaction (SETUP / STROBE / RELEASE) to a single peripheral, one response out.
module uniboard_bus_master #(
    parameter int NUM_PERIPH  = 4,
    parameter int SELECT_HOLD = 4
) (
    input  logic                  clk_12MHz,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_periph,
    input  logic [7:0]            cmd_addr,
    input  logic                  cmd_rw,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [2:0]            rsp_size,
    output logic                  rsp_error,
    inout  wire  [31:0]           databus,
    input  logic [2:0]            reg_size,
    output logic [7:0]            register_addr,
    output logic                  rw,
    output logic [NUM_PERIPH-1:0] select
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RESP} state_t;

    localparam logic [7:0] NUM_PERIPH_B = 8'(NUM_PERIPH);

    state_t      state;
    state_t      state_next;
    logic [3:0]  hold_cnt;
    logic [2:0]  periph_q;
    logic [31:0] wdata_q;
    logic        drive_en;
    logic        accept;
    logic        bad_index;

    assign accept    = cmd_valid & cmd_ready;
    assign bad_index = (cmd_periph >= NUM_PERIPH_B);

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk_12MHz) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: each always_comb assigns its outputs a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bad_index ? RESP : SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (hold_cnt == 4'd1) state_next = RELEASE;
            RELEASE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cmd_ready is gated by reset so no command is taken while reset is held.
    always_comb begin
        cmd_ready = (state == IDLE) & reset;
        rsp_valid = (state == RESP);
        drive_en  = ((state == SETUP) || (state == STROBE)) && !rw;
        select    = '0;
        for (int i = 0; i < NUM_PERIPH; i++)
            select[i] = (state == STROBE) && (periph_q == 3'(i));
    end

    assign databus = drive_en ? wdata_q : 32'bz;

    always_ff @(posedge clk_12MHz) begin
        if (!reset) begin
            register_addr <= 8'd0;
            rw            <= 1'b1;
            wdata_q       <= 32'd0;
            periph_q      <= 3'd0;
            hold_cnt      <= 4'd0;
            rsp_data      <= 32'd0;
            rsp_size      <= 3'd0;
            rsp_error     <= 1'b0;
        end else begin
            if (accept) begin
                hold_cnt <= 4'(SELECT_HOLD);
                if (bad_index) begin
                    rsp_error <= 1'b1;
                    rsp_size  <= 3'd0;
                    rsp_data  <= 32'd0;
                end else begin
                    register_addr <= cmd_addr;
                    rw            <= cmd_rw;
                    wdata_q       <= cmd_wdata;
                    periph_q      <= cmd_periph[2:0];
                end
            end
            if (state == STROBE) begin
                hold_cnt <= hold_cnt - 4'd1;
                // Final strobe edge: the peripheral's reply has been stable for at least one cycle.
                if (hold_cnt == 4'd1) begin
                    rsp_size  <= reg_size;
                    rsp_error <= (reg_size == 3'd0);
                    rsp_data  <= (rw && reg_size != 3'd0) ? databus : 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uniboard_bus_master.sv
// Randomized scoreboard bench for uniboard_bus_master with a register-file peripheral model
// on the bus side and a command-level reference memory on the stimulus side.
module tb_uniboard_bus_master;

    localparam int NP    = 4;
    localparam int SH    = 4;
    localparam int NADDR = 16;

    logic        clk_12MHz = 1'b0;
    logic        reset     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_periph = 8'd0;
    logic [7:0]  cmd_addr   = 8'd0;
    logic        cmd_rw     = 1'b0;
    logic [31:0] cmd_wdata  = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b1;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_size;
    logic        rsp_error;
    wire  [31:0] databus;
    logic [2:0]  reg_size;
    logic [7:0]  register_addr;
    logic        rw;
    logic [NP-1:0] select;

    always #5 clk_12MHz = ~clk_12MHz;

    uniboard_bus_master #(.NUM_PERIPH(NP), .SELECT_HOLD(SH)) dut (
        .clk_12MHz(clk_12MHz), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_periph(cmd_periph),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_size(rsp_size), .rsp_error(rsp_error),
        .databus(databus), .reg_size(reg_size), .register_addr(register_addr),
        .rw(rw), .select(select)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = -1;

    always @(posedge clk_12MHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- peripheral register files ----------------
    logic [2:0]  tbl_size [NP][NADDR];
    logic [31:0] ref_mem  [NP][NADDR];
    logic [31:0] per_mem  [NP][NADDR];
    bit          per_wr   [NP][NADDR];

    function automatic logic [31:0] init_word(int p, int a);
        if (p == 1 && a == 3) return 32'h0000_007F;
        return {8'(p), 8'(a), 16'hC0DE ^ 16'(p * 37 + a * 11)};
    endfunction

    function automatic int sel_index(logic [NP-1:0] s);
        for (int i = 0; i < NP; i++) if (s[i]) return i;
        return 0;
    endfunction

    int          sel_cnt = 0;
    logic        periph_drive;
    logic [31:0] periph_val;

    // Peripheral answers from the second strobe cycle; unknown registers report size 0 and all ones.
    always_comb begin
        periph_drive = 1'b0;
        periph_val   = 32'd0;
        reg_size     = 3'd0;
        if (select != '0 && sel_cnt >= 1) begin
            reg_size = tbl_size[sel_index(select)][register_addr[3:0]];
            if (rw) begin
                periph_drive = 1'b1;
                if (reg_size == 3'd0) periph_val = 32'hFFFF_FFFF;
                else if (per_wr[sel_index(select)][register_addr[3:0]])
                    periph_val = per_mem[sel_index(select)][register_addr[3:0]];
                else
                    periph_val = init_word(sel_index(select), int'(register_addr[3:0]));
            end
        end
    end

    assign databus = periph_drive ? periph_val : 32'bz;

    always @(posedge clk_12MHz) begin
        if (select != '0) begin
            sel_cnt <= sel_cnt + 1;
            if (!rw && reg_size != 3'd0) begin
                per_mem[sel_index(select)][register_addr[3:0]] <= databus;
                per_wr[sel_index(select)][register_addr[3:0]]  <= 1'b1;
            end
        end else begin
            sel_cnt <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic err; logic [31:0] data; logic [2:0] size; int rise; } rsp_t;
    typedef struct { int p; logic [7:0] addr; logic rw; logic [31:0] wdata; int acc; } bus_t;
    rsp_t rsp_q[$];
    bus_t bus_q[$];

    task automatic issue(input int p, input int a, input logic r, input logic [31:0] wd,
                         output int acc);
        int   waited;
        rsp_t e;
        bus_t b;
        waited = 0;
        acc    = -1;
        cmd_valid = 1'b1; cmd_periph = 8'(p); cmd_addr = 8'(a); cmd_rw = r; cmd_wdata = wd;
        forever begin
            @(negedge clk_12MHz);
            if (cmd_ready && reset) break;
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 32'd0, 32'd1);
                cmd_valid = 1'b0;
                return;
            end
        end
        acc = cyc + 1;
        if (p >= NP) begin
            e = '{err: 1'b1, data: 32'd0, size: 3'd0, rise: acc};
        end else begin
            e.size = tbl_size[p][a];
            e.err  = (e.size == 3'd0);
            e.data = (r && !e.err) ? ref_mem[p][a] : 32'd0;
            e.rise = acc + SH + 2;
            if (!r && !e.err) ref_mem[p][a] = wd;
            b = '{p: p, addr: 8'(a), rw: r, wdata: wd, acc: acc};
            bus_q.push_back(b);
        end
        rsp_q.push_back(e);
        @(posedge clk_12MHz); #1;
        cmd_valid = 1'b0;
    endtask

    // Response monitor: pops one expectation per response and re-checks it every held cycle.
    rsp_t cur;
    bit   have_rsp = 0;
    always @(negedge clk_12MHz) begin
        if (rsp_valid) begin
            if (!have_rsp) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur = rsp_q.pop_front();
                    have_rsp = 1;
                    check("rsp_latency", cyc, cur.rise);
                end
            end
            if (have_rsp) begin
                check("rsp_data", rsp_data, cur.data);
                check("rsp_size", 32'(rsp_size), 32'(cur.size));
                check("rsp_error", 32'(rsp_error), 32'(cur.err));
            end
            check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
            if (rsp_ready && reset) begin
                have_rsp = 0;
                hs_cyc   = cyc + 1;
            end
        end
        if (!reset) have_rsp = 0;
    end

    // Bus monitor: phase 0 is SETUP, 1..SH STROBE, SH+1 RELEASE; select must be idle otherwise.
    logic [NP-1:0] exp_sel;
    bus_t          bt;
    int            ph;
    always @(negedge clk_12MHz) begin
        exp_sel = '0;
        if (bus_q.size() != 0) begin
            bt = bus_q[0];
            ph = cyc - bt.acc;
            if (ph >= 0 && ph <= SH + 1) begin
                if (ph >= 1 && ph <= SH) exp_sel[bt.p] = 1'b1;
                if (ph <= SH) begin
                    check("bus_addr", 32'(register_addr), 32'(bt.addr));
                    check("bus_rw", 32'(rw), 32'(bt.rw));
                    if (!bt.rw) check("bus_wdata", databus, bt.wdata);
                end
            end
            if (ph == SH + 1) void'(bus_q.pop_front());
        end
        check("select", 32'(select), 32'(exp_sel));
    end

    bit rand_ready = 0;
    bit hold_off   = 0;
    always @(posedge clk_12MHz) begin
        #1;
        if (hold_off)        rsp_ready = 1'b0;
        else if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        else                 rsp_ready = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc1, acc2, p, waited;
        for (int i = 0; i < NP; i++)
            for (int j = 0; j < NADDR; j++) begin
                tbl_size[i][j] = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 4));
                ref_mem[i][j]  = init_word(i, j);
            end
        tbl_size[0][1] = 3'd1;
        tbl_size[1][3] = 3'd1;
        tbl_size[2][5] = 3'd0;
        tbl_size[3][2] = 3'd0;

        // Reset state
        repeat (3) @(posedge clk_12MHz);
        @(negedge clk_12MHz);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_addr", 32'(register_addr), 32'd0);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_size", 32'(rsp_size), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        @(posedge clk_12MHz); #1;
        reset = 1'b1;
        @(negedge clk_12MHz);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk_12MHz); #1;

        // Directed cases: write, read-back, read, unknown register, bad index
        issue(0, 1, 1'b0, 32'h0000_00A5, acc);
        issue(0, 1, 1'b1, 32'h0, acc);
        issue(1, 3, 1'b1, 32'h0, acc);
        issue(2, 5, 1'b1, 32'h0, acc);
        issue(9, 0, 1'b1, 32'h0, acc);

        // Backpressure: response held 20 cycles while the next command waits on cmd_valid
        hold_off = 1;
        repeat (2) @(posedge clk_12MHz); #1;
        issue(1, 3, 1'b1, 32'h0, acc1);
        fork
            issue(0, 1, 1'b1, 32'h0, acc2);
            begin
                while (cyc < acc1 + SH + 2 + 20) @(negedge clk_12MHz);
                hold_off = 0;
            end
        join
        check("accept_after_hs", acc2, hs_cyc + 1);

        // Reset during the second strobe cycle of a write
        issue(3, 2, 1'b0, 32'hDEAD_BEEF, acc);
        while (cyc < acc + 2) begin @(posedge clk_12MHz); #1; end
        reset = 1'b0;
        @(posedge clk_12MHz); #1;
        rsp_q.delete();
        bus_q.delete();
        @(negedge clk_12MHz);
        check("midrst_select", 32'(select), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk_12MHz); #1;
        reset = 1'b1;
        @(negedge clk_12MHz);
        check("midrst_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk_12MHz); #1;

        // Randomized traffic with random response backpressure
        rand_ready = 1;
        repeat (150) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk_12MHz); #1; end
            p = $urandom_range(0, NP + 1);
            if ($urandom_range(0, 9) == 0) p = $urandom_range(NP, 255);
            issue(p, $urandom_range(0, NADDR - 1), 1'($urandom_range(0, 1)), $urandom, acc);
        end

        waited = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && waited < 200) begin
            @(negedge clk_12MHz);
            waited++;
        end
        rand_ready = 0;
        repeat (4) @(negedge clk_12MHz);
        check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
        check("drain_bus_q", 32'(bus_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
